serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell (inputs a, b, cin; outputs sum, carry).
- Sits directly around that cell:
  - Upstream, it shifts operand bits into the cell, LSB first.
  - Downstream, it registers the cell's carry back into cin and collects sum bits into a result register.
- Trades latency (WIDTH cycles) for area.
- Used wherever one adder cell must serve multi-bit operands.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk    input   1      rising-edge system clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request to begin an addition; sampled on rising clk edge
- a      input   WIDTH  operand A; captured when start is accepted
- b      input   WIDTH  operand B; captured when start is accepted
- cin    input   1      initial carry-in; captured when start is accepted
- busy   output  1      high while a serial addition is in progress
- done   output  1      one-cycle pulse: sum/cout newly valid
- sum    output  WIDTH  result a+b+cin, low WIDTH bits; held until the next completion
- cout   output  1      carry out of bit WIDTH-1; held with sum

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset rst_n is asynchronous, active-low.
  - All state updates on the rising clk edge.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, carry flop and bit counter all 0.
- States:
  - IDLE
  - RUN
  - DONE
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at edge E: capture a into shift_a, b into shift_b, cin into carry_q; clear bit count; go to RUN.
  - start = 0: remain in IDLE.
- RUN (busy = 1):
  - Each edge:
    - bit_s = shift_a[0] ^ shift_b[0] ^ carry_q.
    - bit_c = majority(shift_a[0], shift_b[0], carry_q).
    - carry_q <= bit_c.
    - shift_a and shift_b shift right by 1, zero-fill.
    - Result shift register shifts right with bit_s entering at MSB.
    - Count increments.
  - Exactly WIDTH RUN edges: E+1 .. E+WIDTH.
  - On edge E+WIDTH (last bit processed):
    - sum <= completed result, including the final bit_s.
    - cout <= final bit_c.
    - Go to DONE.
- DONE:
  - Lasts exactly one cycle: done = 1, busy = 0.
  - If start = 1 on the edge leaving DONE: accepted exactly as in IDLE (back-to-back operation, no idle bubble); go to RUN.
  - Otherwise go to IDLE.
- Latency:
  - start accepted at edge E.
  - done high from edge E+WIDTH to edge E+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy = 1 is ignored:
  - No capture, no restart.
  - The operation in progress is unaffected.
- sum/cout:
  - Change only on the completing edge.
  - Stable during RUN; keep the previous result.
  - Stable in IDLE.
- a, b and cin may change freely after the accepting edge; the captured values are used.
- Arithmetic: {cout, sum} == a + b + cin, exact modulo 2^(WIDTH+1). Wrap-around to sum = 0 with cout = 1 is legal.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate (asynchronous) abort to reset values.
  - No done pulse.
  - sum/cout cleared.
  - After rst_n deasserts, the first start is accepted normally.
- busy and done are never high simultaneously.

Test Plan:
1. WIDTH=8: a=8'h0F, b=8'h01, cin=0, start at edge E -> busy high edges E..E+8, done pulse from edge E+8 for 1 cycle; sum=8'h10, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (wrap-around). Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
3. Start a=8'h12, b=8'h34; at edge E+3 pulse start with a=8'hFF, b=8'hFF -> ignored; sum=8'h46, cout=0, done exactly once at E+8.
4. Start a=8'hAA, b=8'h55, cin=1; hold start high through DONE with a=8'h01, b=8'h02, cin=0:
   - First result: sum=8'h00, cout=1 at E+8.
   - Second accepted at E+9; sum=8'h03, cout=0 at E+17.
5. Start a=8'h80, b=8'h80; drop rst_n low asynchronously mid-cycle at E+4:
   - Outputs go 0 immediately, no done.
   - Release, then start a=8'h80, b=8'h80 -> sum=8'h00, cout=1 at 8 edges after the new accept.
6. Parameter WIDTH=4: exhaustive sweep of all a, b, cin (512 cases), back-to-back -> every {cout, sum} equals a+b+cin, done spacing exactly 5 cycles.

Source files
------------

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for the bit-serial adder
// Master drives the operands and start; slave returns status and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one full-adder cell
// Operands shift out LSB first; the carry loops back through carry_q, sum bits fill res from the MSB.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_s, bit_c;
  logic [WIDTH-1:0] res_next;

  // The single full-adder cell shared by every bit position.
  assign bit_s    = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign bit_c    = (shift_a_q[0] & shift_b_q[0]) | (shift_a_q[0] & carry_q) |
                    (shift_b_q[0] & carry_q);
  assign res_next = {bit_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    case (state_q)
      RUN: begin
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        res_d     = res_next;
        carry_d   = bit_c;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_next;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back throughput.
        state_d = IDLE;
        if (bus.start) begin
          shift_a_d = bus.a;
          shift_b_d = bus.b;
          carry_d   = bus.cin;
          res_d     = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder at WIDTH 8 and 4
// Expected results come from plain integer addition of the operands.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [8:0] prev8 = '0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(4)) b4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit addition accepted at the first tick; inj>0 pulses a stray start at edge E+inj.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input int inj);
    logic [8:0] exp;
    exp = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
    b8.start = 1'b1; b8.a = ia; b8.b = ib; b8.cin = ic;
    tick;
    b8.start = 1'b0;
    b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
    chk("accept_busy", {b8.busy, b8.done, b8.cout, b8.sum}, {2'b10, prev8});
    for (int k = 1; k < 8; k++) begin
      if (k == inj) begin
        b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF;
      end
      tick;
      b8.start = 1'b0;
      chk("run_hold", {b8.busy, b8.done, b8.cout, b8.sum}, {2'b10, prev8});
    end
    tick;
    chk("done_flags", {b8.busy, b8.done}, 2'b01);
    chk("result8", {b8.cout, b8.sum}, exp);
    prev8 = exp;
  endtask

  initial begin
    logic [4:0] e4;
    b8.start = 0; b8.a = 0; b8.b = 0; b8.cin = 0;
    b4.start = 0; b4.a = 0; b4.b = 0; b4.cin = 0;
    #12;
    chk("reset8", {b8.busy, b8.done, b8.cout, b8.sum}, 0);
    chk("reset4", {b4.busy, b4.done, b4.cout, b4.sum}, 0);
    #4 rst_n = 1'b1;
    tick;
    chk("idle8", {b8.busy, b8.done, b8.cout, b8.sum}, 0);

    op8(8'h0F, 8'h01, 1'b0, 0);
    tick;
    chk("done_pulse", {b8.busy, b8.done, b8.cout, b8.sum}, {2'b00, prev8});
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    tick;
    op8(8'h12, 8'h34, 1'b0, 3);
    tick;
    chk("no_second_done", {b8.busy, b8.done}, 2'b00);
    op8(8'hAA, 8'h55, 1'b1, 0);
    op8(8'h01, 8'h02, 1'b0, 0);
    tick;

    // Async reset in the middle of a run.
    b8.start = 1'b1; b8.a = 8'h80; b8.b = 8'h80; b8.cin = 1'b0;
    tick;
    b8.start = 1'b0;
    repeat (4) tick;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {b8.busy, b8.done, b8.cout, b8.sum}, 0);
    prev8 = '0;
    tick;
    tick;
    chk("rst_hold", {b8.busy, b8.done, b8.cout, b8.sum}, 0);
    #2 rst_n = 1'b1;
    tick;
    op8(8'h80, 8'h80, 1'b0, 0);
    tick;

    for (int n = 0; n < 24; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 9)));
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;

    // Exhaustive WIDTH=4, issued back to back: each done lands exactly 5 edges after the last.
    for (int i = 0; i < 512; i++) begin
      b4.start = 1'b1; b4.a = 4'(i); b4.b = 4'(i >> 4); b4.cin = 1'(i >> 8);
      e4 = 5'(i & 15) + 5'((i >> 4) & 15) + 5'((i >> 8) & 1);
      tick;
      b4.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick;
        chk("w4_run", {b4.busy, b4.done}, 2'b10);
      end
      tick;
      chk("w4_done", {b4.busy, b4.done, b4.cout, b4.sum}, {2'b01, e4});
    end
    tick;
    chk("w4_idle", {b4.busy, b4.done}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
